// File: rtl/uart_controller_pkg.sv
// Shared definitions for the UART receiver burst controller.
//   - Command codes recognised in IDLE.
//   - FSM state encoding.
//   - Register-file addresses used for the ALU operands.
package uart_controller_pkg;

    localparam logic [7:0] CMD_WRITE       = 8'hAA;
    localparam logic [7:0] CMD_READ        = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPS     = 8'hCC;
    localparam logic [7:0] CMD_ALU_FUNC    = 8'hDD;
    localparam logic [7:0] CMD_BURST_WRITE = 8'hEE;
    localparam logic [7:0] CMD_BURST_READ  = 8'hFF;

    localparam int ALU_ADDR_A = 0;
    localparam int ALU_ADDR_B = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUNC,
        S_ALU_WAIT,
        S_BW_ADDR,
        S_BW_COUNT,
        S_BW_DATA,
        S_BR_ADDR,
        S_BR_COUNT,
        S_BR_ISSUE,
        S_BR_WAIT
    } state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the UART frame decoder.
// Ports:
//   clk        - clock
//   reset      - synchronous active-high reset
//   count_en_i - count this cycle (frame in progress and block enabled)
//   clear_i    - restart the count (byte accepted or new state entered)
//   expire_o   - single-cycle pulse on the TIMEOUT_CYCLES-th counted cycle
module uart_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // A clear in the same cycle suppresses expiry, so an arriving byte wins.
    assign expire_o = count_en_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (count_en_i) begin
            if (expire_o) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_receiver_burst_controller.sv
// UART receiver command decoder: turns received bytes into register-file
// writes/reads (single and burst, with address wrap) and ALU requests,
// with inter-byte timeout and frame-error reporting.
// Optional macro FRAME_COUNTERS_EN adds frame_count / error_count outputs.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   enable                            - block enable; low freezes FSM and timeout
//   parallel_data_valid_synchronized  - received byte strobe
//   parallel_data_synchronized        - received byte
//   ALU_result_valid                  - ALU finished its operation
//   read_data_valid                   - read data consumed by the TX path
//   ALU_function, ALU_enable, ALU_clk_enable - ALU control
//   address, write_enable, write_data, read_enable - register-file access
//   frame_error                       - pulse on aborted/illegal frame
//   busy                              - frame in progress
//   frame_count, error_count          - (FRAME_COUNTERS_EN) saturating counters
module uart_receiver_burst_controller
    import uart_controller_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int ALU_FUNCTION_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES      = 4096,
    parameter int MAX_BURST_LENGTH    = 16,
    localparam int AW = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          parallel_data_valid_synchronized,
    input  logic [DATA_WIDTH-1:0]         parallel_data_synchronized,
    input  logic                          ALU_result_valid,
    input  logic                          read_data_valid,
    output logic [ALU_FUNCTION_WIDTH-1:0] ALU_function,
    output logic                          ALU_enable,
    output logic                          ALU_clk_enable,
    output logic [AW-1:0]                 address,
    output logic                          write_enable,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          read_enable,
    output logic                          frame_error,
    output logic                          busy
`ifdef FRAME_COUNTERS_EN
    ,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   error_count
`endif
);

    state_t                        state_q;
    state_t                        state_prev_q;
    logic [AW-1:0]                 addr_q;        // running burst address
    logic [DATA_WIDTH-1:0]         remain_q;      // burst transfers still to do
    logic [ALU_FUNCTION_WIDTH-1:0] alu_fn_q;
    logic                          alu_en_q;
    logic [AW-1:0]                 address_q;
    logic                          write_enable_q;
    logic [DATA_WIDTH-1:0]         write_data_q;
    logic                          read_enable_q;
    logic                          frame_error_q;
    logic                          busy_q;
    logic                          frame_done_q;  // frame finished cleanly

    logic                  accept;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  tmo_expire;
    logic                  tmo_clear;

    function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
        return (a == AW'(REGISTER_FILE_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic count_ok(input logic [DATA_WIDTH-1:0] c);
        return (c != '0) && (int'(c) <= MAX_BURST_LENGTH);
    endfunction

    assign accept  = enable && parallel_data_valid_synchronized;
    assign rx_byte = parallel_data_synchronized;
    // state_prev_q lags state_q by one cycle, so a mismatch marks a state entry.
    assign tmo_clear = accept || (state_q != state_prev_q);

    uart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .count_en_i(enable && (state_q != S_IDLE)),
        .clear_i   (tmo_clear),
        .expire_o  (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            state_prev_q   <= S_IDLE;
            addr_q         <= '0;
            remain_q       <= '0;
            alu_fn_q       <= '0;
            alu_en_q       <= 1'b0;
            address_q      <= '0;
            write_enable_q <= 1'b0;
            write_data_q   <= '0;
            read_enable_q  <= 1'b0;
            frame_error_q  <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            frame_error_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            state_prev_q   <= state_q;

            if (enable) begin
                if (tmo_expire) begin
                    frame_error_q <= 1'b1;
                    alu_en_q      <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end else begin
                    unique case (state_q)
                        S_IDLE: if (accept) begin
                            busy_q <= 1'b1;
                            case (rx_byte)
                                CMD_WRITE:       state_q <= S_WR_ADDR;
                                CMD_READ:        state_q <= S_RD_ADDR;
                                CMD_ALU_OPS:     state_q <= S_ALU_A;
                                CMD_ALU_FUNC:    state_q <= S_ALU_FUNC;
                                CMD_BURST_WRITE: state_q <= S_BW_ADDR;
                                CMD_BURST_READ:  state_q <= S_BR_ADDR;
                                default: begin
                                    frame_error_q <= 1'b1;
                                    busy_q        <= 1'b0;
                                end
                            endcase
                        end
                        S_WR_ADDR: if (accept) begin
                            addr_q  <= rx_byte[AW-1:0];
                            state_q <= S_WR_DATA;
                        end
                        S_WR_DATA: if (accept) begin
                            address_q      <= addr_q;
                            write_data_q   <= rx_byte;
                            write_enable_q <= 1'b1;
                            frame_done_q   <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= S_IDLE;
                        end
                        S_RD_ADDR: if (accept) begin
                            address_q     <= rx_byte[AW-1:0];
                            read_enable_q <= 1'b1;
                            state_q       <= S_RD_WAIT;
                        end
                        S_RD_WAIT: if (read_data_valid) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                        S_ALU_A: if (accept) begin
                            address_q      <= AW'(ALU_ADDR_A);
                            write_data_q   <= rx_byte;
                            write_enable_q <= 1'b1;
                            state_q        <= S_ALU_B;
                        end
                        S_ALU_B: if (accept) begin
                            address_q      <= AW'(ALU_ADDR_B);
                            write_data_q   <= rx_byte;
                            write_enable_q <= 1'b1;
                            state_q        <= S_ALU_FUNC;
                        end
                        S_ALU_FUNC: if (accept) begin
                            alu_fn_q <= rx_byte[ALU_FUNCTION_WIDTH-1:0];
                            alu_en_q <= 1'b1;
                            state_q  <= S_ALU_WAIT;
                        end
                        S_ALU_WAIT: if (ALU_result_valid) begin
                            alu_en_q     <= 1'b0;
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                        S_BW_ADDR: if (accept) begin
                            addr_q  <= rx_byte[AW-1:0];
                            state_q <= S_BW_COUNT;
                        end
                        S_BW_COUNT: if (accept) begin
                            if (count_ok(rx_byte)) begin
                                remain_q <= rx_byte;
                                state_q  <= S_BW_DATA;
                            end else begin
                                frame_error_q <= 1'b1;
                                busy_q        <= 1'b0;
                                state_q       <= S_IDLE;
                            end
                        end
                        S_BW_DATA: if (accept) begin
                            address_q      <= addr_q;
                            write_data_q   <= rx_byte;
                            write_enable_q <= 1'b1;
                            addr_q         <= inc_addr(addr_q);
                            remain_q       <= remain_q - 1'b1;
                            if (remain_q == DATA_WIDTH'(1)) begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= S_IDLE;
                            end
                        end
                        S_BR_ADDR: if (accept) begin
                            addr_q  <= rx_byte[AW-1:0];
                            state_q <= S_BR_COUNT;
                        end
                        S_BR_COUNT: if (accept) begin
                            if (count_ok(rx_byte)) begin
                                remain_q <= rx_byte;
                                state_q  <= S_BR_ISSUE;
                            end else begin
                                frame_error_q <= 1'b1;
                                busy_q        <= 1'b0;
                                state_q       <= S_IDLE;
                            end
                        end
                        // Bytes arriving during the burst-read phase are dropped.
                        S_BR_ISSUE: begin
                            address_q     <= addr_q;
                            read_enable_q <= 1'b1;
                            state_q       <= S_BR_WAIT;
                        end
                        S_BR_WAIT: if (read_data_valid) begin
                            addr_q   <= inc_addr(addr_q);
                            remain_q <= remain_q - 1'b1;
                            if (remain_q == DATA_WIDTH'(1)) begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                state_q <= S_BR_ISSUE;
                            end
                        end
                        default: begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign ALU_function   = alu_fn_q;
    assign ALU_enable     = alu_en_q;
    assign ALU_clk_enable = alu_en_q;
    assign address        = address_q;
    assign write_enable   = write_enable_q;
    assign write_data     = write_data_q;
    assign read_enable    = read_enable_q;
    assign frame_error    = frame_error_q;
    assign busy           = busy_q;

`ifdef FRAME_COUNTERS_EN
    logic [15:0] frame_count_q;
    logic [15:0] error_count_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
            error_count_q <= '0;
        end else begin
            if (frame_done_q) frame_count_q <= sat_inc(frame_count_q);
            if (frame_error_q) error_count_q <= sat_inc(error_count_q);
        end
    end

    assign frame_count = frame_count_q;
    assign error_count = error_count_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_uart_receiver_burst_controller.sv
// Directed bench for uart_receiver_burst_controller: a per-cycle vector
// table plus hand-written sequences for timeout and mid-frame reset.
module tb_uart_receiver_burst_controller;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int FW   = 4;
    localparam int TMO  = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          valid;
    logic [DW-1:0] data;
    logic          arv;
    logic          rdv;
    logic [FW-1:0] ALU_function;
    logic          ALU_enable;
    logic          ALU_clk_enable;
    logic [AW-1:0] address;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic          frame_error;
    logic          busy;
`ifdef FRAME_COUNTERS_EN
    logic [15:0]   frame_count;
    logic [15:0]   error_count;
`endif

    int checks = 0;
    int errors = 0;

    uart_receiver_burst_controller #(
        .DATA_WIDTH(DW),
        .REGISTER_FILE_DEPTH(16),
        .ALU_FUNCTION_WIDTH(FW),
        .TIMEOUT_CYCLES(TMO),
        .MAX_BURST_LENGTH(16)
    ) dut (
        .clk                             (clk),
        .reset                           (reset),
        .enable                          (enable),
        .parallel_data_valid_synchronized(valid),
        .parallel_data_synchronized      (data),
        .ALU_result_valid                (arv),
        .read_data_valid                 (rdv),
        .ALU_function                    (ALU_function),
        .ALU_enable                      (ALU_enable),
        .ALU_clk_enable                  (ALU_clk_enable),
        .address                         (address),
        .write_enable                    (write_enable),
        .write_data                      (write_data),
        .read_enable                     (read_enable),
        .frame_error                     (frame_error),
        .busy                            (busy)
`ifdef FRAME_COUNTERS_EN
        ,
        .frame_count                     (frame_count),
        .error_count                     (error_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          v;
        logic [7:0]  d;
        bit          rdv;
        bit          arv;
        bit          we;
        bit          re;
        bit          fe;
        bit          bsy;
        bit          alu;
        logic [3:0]  fn;
        logic [3:0]  addr;
        logic [7:0]  wd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit en, bit v, logic [7:0] d, bit r, bit a,
                               bit we, bit re, bit fe, bit bsy, bit alu,
                               logic [3:0] fn, logic [3:0] addr, logic [7:0] wd);
        vec_t t;
        t.en = en; t.v = v; t.d = d; t.rdv = r; t.arv = a;
        t.we = we; t.re = re; t.fe = fe; t.bsy = bsy; t.alu = alu;
        t.fn = fn; t.addr = addr; t.wd = wd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return just after the rising edge.
    task automatic drive(input bit en, input bit v, input logic [7:0] d, input bit r, input bit a);
        @(negedge clk);
        enable = en; valid = v; data = d; rdv = r; arv = a;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input int idx);
        logic [31:0] act;
        logic [31:0] exp;
        drive(t.en, t.v, t.d, t.rdv, t.arv);
        exp = {10'd0, t.we, t.re, t.fe, t.bsy, t.alu, t.alu, t.fn,
               (t.we || t.re) ? t.addr : 4'h0, t.we ? t.wd : 8'h00};
        act = {10'd0, write_enable, read_enable, frame_error, busy, ALU_enable, ALU_clk_enable,
               ALU_function, (t.we || t.re) ? address : 4'h0, t.we ? write_data : 8'h00};
        check($sformatf("vec%0d", idx), act, exp);
    endtask

    initial begin
        int n;
        bit saw_we;

        reset = 1'b1; enable = 1'b0; valid = 1'b0; data = '0; rdv = 1'b0; arv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {ALU_function, ALU_enable, ALU_clk_enable, address, write_enable,
               write_data, read_enable, frame_error, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //           en v  d     r a  we re fe by alu fn    addr   wd
        // WRITE 0x0D <- 0xCF
        tbl.push_back(V(1,1,8'hAA,0,0, 0,0,0,1,0, 4'h0,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h0D,0,0, 0,0,0,1,0, 4'h0,4'h0,8'h00));
        tbl.push_back(V(1,1,8'hCF,0,0, 1,0,0,0,0, 4'h0,4'hD,8'hCF));
        tbl.push_back(V(1,0,8'h00,0,0, 0,0,0,0,0, 4'h0,4'h0,8'h00));
        // byte with enable low is ignored; stray handshakes in IDLE ignored
        tbl.push_back(V(0,1,8'hAA,0,0, 0,0,0,0,0, 4'h0,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,1,1, 0,0,0,0,0, 4'h0,4'h0,8'h00));
        // READ 0x08
        tbl.push_back(V(1,1,8'hBB,0,0, 0,0,0,1,0, 4'h0,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h08,0,0, 0,1,0,1,0, 4'h0,4'h8,8'h00));
        tbl.push_back(V(1,0,8'h00,0,0, 0,0,0,1,0, 4'h0,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,1,0, 0,0,0,0,0, 4'h0,4'h0,8'h00));
        // ALU_OPS A=0x09 B=0x0A func=4
        tbl.push_back(V(1,1,8'hCC,0,0, 0,0,0,1,0, 4'h0,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h09,0,0, 1,0,0,1,0, 4'h0,4'h0,8'h09));
        tbl.push_back(V(1,1,8'h0A,0,0, 1,0,0,1,0, 4'h0,4'h1,8'h0A));
        tbl.push_back(V(1,1,8'h04,0,0, 0,0,0,1,1, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,0,0, 0,0,0,1,1, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,0,1, 0,0,0,0,0, 4'h4,4'h0,8'h00));
        // BURST_WRITE at 0xE, count 3, wraps to 0
        tbl.push_back(V(1,1,8'hEE,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h0E,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h03,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h11,0,0, 1,0,0,1,0, 4'h4,4'hE,8'h11));
        tbl.push_back(V(1,1,8'h22,0,0, 1,0,0,1,0, 4'h4,4'hF,8'h22));
        tbl.push_back(V(1,1,8'h33,0,0, 1,0,0,0,0, 4'h4,4'h0,8'h33));
        // BURST_READ at 0xF, count 2, wraps to 0
        tbl.push_back(V(1,1,8'hFF,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h0F,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h02,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,0,0, 0,1,0,1,0, 4'h4,4'hF,8'h00));
        tbl.push_back(V(1,0,8'h00,1,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,0,0, 0,1,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,1,0, 0,0,0,0,0, 4'h4,4'h0,8'h00));
        // unknown command
        tbl.push_back(V(1,1,8'h5A,0,0, 0,0,1,0,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,0,0, 0,0,0,0,0, 4'h4,4'h0,8'h00));
        // burst count 0 and count 17 are illegal
        tbl.push_back(V(1,1,8'hEE,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h05,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h00,0,0, 0,0,1,0,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'hFF,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h05,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h11,0,0, 0,0,1,0,0, 4'h4,4'h0,8'h00));
        // ALU_FUNC func=7
        tbl.push_back(V(1,1,8'hDD,0,0, 0,0,0,1,0, 4'h4,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h07,0,0, 0,0,0,1,1, 4'h7,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,0,1, 0,0,0,0,0, 4'h7,4'h0,8'h00));
        // address upper bits ignored
        tbl.push_back(V(1,1,8'hAA,0,0, 0,0,0,1,0, 4'h7,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h3D,0,0, 0,0,0,1,0, 4'h7,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h5E,0,0, 1,0,0,0,0, 4'h7,4'hD,8'h5E));
        // byte during RD_WAIT is dropped, so the following 0x01 is a bad command
        tbl.push_back(V(1,1,8'hBB,0,0, 0,0,0,1,0, 4'h7,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h02,0,0, 0,1,0,1,0, 4'h7,4'h2,8'h00));
        tbl.push_back(V(1,1,8'hAA,0,0, 0,0,0,1,0, 4'h7,4'h0,8'h00));
        tbl.push_back(V(1,0,8'h00,1,0, 0,0,0,0,0, 4'h7,4'h0,8'h00));
        tbl.push_back(V(1,1,8'h01,0,0, 0,0,1,0,0, 4'h7,4'h0,8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Timeout: AA, 0x03, then silence.
        drive(1, 1, 8'hAA, 0, 0);
        drive(1, 1, 8'h03, 0, 0);
        n = -1;
        saw_we = 1'b0;
        for (int k = 1; k <= TMO + 20; k++) begin
            drive(1, 0, 8'h00, 0, 0);
            if (write_enable) saw_we = 1'b1;
            if (frame_error) begin
                n = k;
                break;
            end
        end
        check("timeout_latency_in_window", {31'd0, (n >= TMO - 2) && (n <= TMO + 3)}, 32'd1);
        check("timeout_no_write", {31'd0, saw_we}, 32'd0);
        check("timeout_busy_low", {31'd0, busy}, 32'd0);
        drive(1, 0, 8'h00, 0, 0);
        check("timeout_fe_one_cycle", {31'd0, frame_error}, 32'd0);

        // Reset mid-frame: AA, 0x03, reset, 0x44.
        drive(1, 1, 8'hAA, 0, 0);
        drive(1, 1, 8'h03, 0, 0);
        @(negedge clk);
        reset = 1'b1; valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_outputs", {29'd0, write_enable, frame_error, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0; enable = 1'b1; valid = 1'b1; data = 8'h44;
        @(posedge clk);
        #1;
        check("after_reset_0x44", {29'd0, write_enable, frame_error, busy}, 32'd2);
        drive(1, 0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
